sdram_line_cache: RTL and testbench
===================================

# sdram_line_cache

Direct-mapped, write-through read cache between the CPU memory bus and `SDRAMcontroller`. It drives the controller's request side: `sdc_addr`, `sdc_data`, `sdc_we` and `sdc_start`. It consumes the controller's 256-bit line reads through `sdc_q`, `sdc_ack` and `sdc_busy`. Read hits are served from on-chip line storage in one cycle. Read misses fetch a full 8-word line, and every write is forwarded to SDRAM.

## Interface
- `INDEX_BITS`, default 3: log2 of the line count (8 lines × 8 words × 32 bits).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_addr` in 24: word address, sampled when a request is accepted.
- `cpu_data` in 32: write data, sampled when a request is accepted.
- `cpu_we` in 1: 1 = write, 0 = read; sampled when a request is accepted.
- `cpu_start` in 1: request strobe; sampled only in IDLE.
- `cpu_q` out 32: read data, valid in the cycle `cpu_done` is high and held until the next read completes.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_busy` out 1: high in every state except IDLE.
- `sdc_addr` out 24: SDRAM word address; line-aligned (`[2:0]`=0) for reads.
- `sdc_data` out 32: write data to the controller.
- `sdc_we` out 1: write enable to the controller.
- `sdc_start` out 1: controller request; held high until `sdc_ack`.
- `sdc_q` in 256: line from the controller; word 0 is `[255:224]` and word 7 is `[31:0]`.
- `sdc_ack` in 1: controller has accepted the request.
- `sdc_busy` in 1: high from the `sdc_ack` cycle until the operation completes.

## Operation
- Address split:
  - offset = `addr[2:0]`
  - index = `addr[3+INDEX_BITS-1:3]`
  - tag = `addr[23:3+INDEX_BITS]` (18 bits at the default)
- Storage per line: valid bit, tag, and 256-bit data. Storage is register or LUT based; there is no RAM read latency.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE with `cpu_start`=1: capture `cpu_addr`, `cpu_data` and `cpu_we`, then:
  - **Read hit** (valid and tag match): `cpu_q` ← cached word and `cpu_done`=1 on the next edge; stay in IDLE.
  - **Read miss**: `sdc_addr` ← {addr[23:3], 3'b000}, `sdc_we`=0, `sdc_start`=1; go to RD_REQ.
  - **Write**: `sdc_addr` ← addr, `sdc_data` ← data, `sdc_we`=1, `sdc_start`=1.
    - If the write hits, the cached word is updated on this same edge.
    - On a write miss there is no allocation.
    - Go to WR_REQ.
- RD_REQ / WR_REQ: hold all `sdc_*` outputs stable. When `sdc_ack`=1: `sdc_start`←0 and go to RD_WAIT / WR_WAIT.
- RD_WAIT, on the first cycle with `sdc_busy`=0:
  - Write `sdc_q` into the line at the captured index, set valid, store the tag.
  - `cpu_q` ← the `sdc_q` word selected by the captured offset.
  - `cpu_done`=1; return to IDLE.
- WR_WAIT, on the first cycle with `sdc_busy`=0: `cpu_done`=1; return to IDLE. `cpu_q` is unchanged.
- `cpu_start` outside IDLE is ignored; the requester must wait for `cpu_done`.

## Timing
- Reset values:
  - state = IDLE
  - all valid bits = 0
  - `cpu_q`=0, `cpu_done`=0
  - `sdc_start`=0, `sdc_we`=0, `sdc_addr`=0, `sdc_data`=0
  - `cpu_busy`=0
- Tag and line data are not reset.
- Read hit: `cpu_start` sampled at edge N → `cpu_done` high for cycle N+1. Back-to-back hits are allowed, one per cycle.
- Miss or write:
  - `sdc_start` rises at edge N.
  - `sdc_start` falls on the edge that samples `sdc_ack`.
  - `cpu_done` pulses in the cycle after the edge that samples `sdc_busy`=0 in the WAIT state.
- The WAIT state ignores `sdc_busy` in the ack cycle itself; it first checks busy one edge after the ack.
- `sdc_ack` and `sdc_busy` are registered only by the FSM; there is no combinational path from `sdc_*` inputs to `sdc_*` outputs.
- Reset mid-operation:
  - Return to IDLE, drop `sdc_start`, invalidate all lines.
  - Any pending `cpu_done` is lost.
- Write to a line currently being filled is impossible, because the FSM is single-issue.
- A line refill replaces the previous tag unconditionally; there is no write-back, since the cache is write-through.

## Test plan
1. Reset, then read 0x000010 with the SDRAM model preloaded with words 0x1000+i at 0x10..0x17:
   - `sdc_start` with `sdc_addr`=0x000010 and `sdc_we`=0.
   - After the controller completes: `cpu_q`=0x1000, one-cycle `cpu_done`.
2. Then read 0x000013 → hit:
   - No `sdc_start`.
   - `cpu_done` one cycle after `cpu_start`.
   - `cpu_q`=0x1003.
3. Write 0xDEADBEEF to 0x000013:
   - `sdc_start` with `sdc_we`=1, `sdc_addr`=0x13, `sdc_data`=0xDEADBEEF; `cpu_done` follows.
   - Then read 0x13 → hit returns 0xDEADBEEF with no SDRAM access.
4. Conflict miss: read 0x000410 (same index, different tag):
   - SDRAM fetch at 0x410.
   - Then read 0x10 misses again and refetches 0x10.
5. Write to uncached 0x000200:
   - SDRAM write occurs.
   - A following read of 0x200 misses, proving no allocation on write.
6. Assert `reset` during RD_WAIT:
   - `sdc_start`=0, `cpu_done`=0, `cpu_busy`=0 next cycle.
   - A prior hit address (0x13) now misses.

Source files
------------

// File: rtl/sdram_line_cache.sv
// Direct-mapped write-through read cache in front of a line-oriented SDRAM controller.
// Latency: read hit returns one cycle after acceptance; a miss or a write waits for the controller.
// Backpressure: cpu_busy is high outside IDLE, and cpu_start is ignored until cpu_done.
module sdram_line_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [23:0]  cpu_addr,
  input  logic [31:0]  cpu_data,
  input  logic         cpu_we,
  input  logic         cpu_start,
  output logic [31:0]  cpu_q,
  output logic         cpu_done,
  output logic         cpu_busy,
  output logic [23:0]  sdc_addr,
  output logic [31:0]  sdc_data,
  output logic         sdc_we,
  output logic         sdc_start,
  input  logic [255:0] sdc_q,
  input  logic         sdc_ack,
  input  logic         sdc_busy
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 21 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [255:0]     r_line [LINES];
  logic [23:0]      r_addr;  // address of the request in flight

  logic [31:0] r_cpu_q;
  logic        r_cpu_done;
  logic [23:0] r_sdc_addr;
  logic [31:0] r_sdc_data;
  logic        r_sdc_we;
  logic        r_sdc_start;

  logic [INDEX_BITS-1:0] w_idx;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_fill_done;
  logic [7:0]            w_cpu_lsb;   // bit position of the addressed word; word 0 sits at the top
  logic [7:0]            w_fill_lsb;

  assign w_idx       = cpu_addr[3 +: INDEX_BITS];
  assign w_tag       = cpu_addr[23 -: TAG_W];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept    = (r_state == S_IDLE) && cpu_start;
  assign w_cpu_lsb   = {~cpu_addr[2:0], 5'd0};
  assign w_fill_idx  = r_addr[3 +: INDEX_BITS];
  assign w_fill_lsb  = {~r_addr[2:0], 5'd0};
  assign w_fill_done = (r_state == S_RD_WAIT) && !sdc_busy;

  assign cpu_q     = r_cpu_q;
  assign cpu_done  = r_cpu_done;
  assign cpu_busy  = (r_state != S_IDLE);
  assign sdc_addr  = r_sdc_addr;
  assign sdc_data  = r_sdc_data;
  assign sdc_we    = r_sdc_we;
  assign sdc_start = r_sdc_start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: hits stay in IDLE, misses and writes go through a request/wait pair.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_start) begin
          if (cpu_we)      w_next = S_WR_REQ;
          else if (!w_hit) w_next = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (sdc_ack)   w_next = S_RD_WAIT;
      S_RD_WAIT: if (!sdc_busy) w_next = S_IDLE;
      S_WR_REQ:  if (sdc_ack)   w_next = S_WR_WAIT;
      S_WR_WAIT: if (!sdc_busy) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Registered CPU and controller outputs; the controller request is held until acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_cpu_q     <= '0;
      r_cpu_done  <= 1'b0;
      r_sdc_addr  <= '0;
      r_sdc_data  <= '0;
      r_sdc_we    <= 1'b0;
      r_sdc_start <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= cpu_addr;
            if (cpu_we) begin
              r_sdc_addr  <= cpu_addr;
              r_sdc_data  <= cpu_data;
              r_sdc_we    <= 1'b1;
              r_sdc_start <= 1'b1;
            end else if (w_hit) begin
              r_cpu_q    <= r_line[w_idx][w_cpu_lsb +: 32];
              r_cpu_done <= 1'b1;
            end else begin
              r_sdc_addr  <= {cpu_addr[23:3], 3'b000};
              r_sdc_we    <= 1'b0;
              r_sdc_start <= 1'b1;
            end
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (sdc_ack) r_sdc_start <= 1'b0;
        end
        S_RD_WAIT: begin
          if (!sdc_busy) begin
            r_cpu_q    <= sdc_q[w_fill_lsb +: 32];
            r_cpu_done <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (!sdc_busy) r_cpu_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Valid bits: cleared by reset, set when a refill lands.
  always_ff @(posedge clk) begin
    if (reset)            r_valid <= '0;
    else if (w_fill_done) r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag and line storage: refill replaces the whole line, a write hit patches one word.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_line[w_fill_idx] <= sdc_q;
      r_tag[w_fill_idx]  <= r_addr[23 -: TAG_W];
    end else if (w_accept && cpu_we && w_hit) begin
      r_line[w_idx][w_cpu_lsb +: 32] <= cpu_data;
    end
  end

endmodule

// File: tb/tb_sdram_line_cache.sv
// Self-checking bench for sdram_line_cache with an SDRAM controller model and a cache model.
// Latency: checks exact hit latency and done timing relative to the controller's busy drop.
// Backpressure: injects ignored cpu_start noise while the cache is busy.
module tb_sdram_line_cache;
  logic         clk = 1'b0;
  logic         reset;
  logic [23:0]  cpu_addr;
  logic [31:0]  cpu_data;
  logic         cpu_we;
  logic         cpu_start;
  logic [31:0]  cpu_q;
  logic         cpu_done;
  logic         cpu_busy;
  logic [23:0]  sdc_addr;
  logic [31:0]  sdc_data;
  logic         sdc_we;
  logic         sdc_start;
  logic [255:0] sdc_q;
  logic         sdc_ack;
  logic         sdc_busy;

  always #5 clk = ~clk;

  sdram_line_cache #(.INDEX_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we), .cpu_start(cpu_start),
    .cpu_q(cpu_q), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
    .sdc_q(sdc_q), .sdc_ack(sdc_ack), .sdc_busy(sdc_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SDRAM contents: unwritten words read back as a pattern of their own address.
  logic [31:0] mem [logic [23:0]];

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return {8'h5A, a};
  endfunction

  function automatic logic [255:0] line_of(input logic [23:0] a);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[255 - 32*i -: 32] = mem_rd({a[23:3], 3'(i)});
    return l;
  endfunction

  // Controller model state.
  int          n_req = 0;
  logic [23:0] req_addr;
  logic [31:0] req_data;
  logic        req_we;
  int          fall_cyc = 0;
  int          force_blen = -1;
  bit          ctl_busy_phase = 0;

  // SDRAM controller: random ack delay, random busy length, garbage on sdc_q until done.
  initial begin : ctl
    int d;
    int blen;
    sdc_ack = 1'b0;
    sdc_busy = 1'b0;
    sdc_q = '0;
    forever begin
      @(negedge clk);
      if (sdc_start === 1'b1 && reset === 1'b0) begin
        n_req++;
        req_addr = sdc_addr;
        req_we   = sdc_we;
        req_data = sdc_data;
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(negedge clk);
          chk("req_hold", 64'({sdc_start, sdc_we, sdc_addr, sdc_data}),
              64'({1'b1, req_we, req_addr, req_data}));
        end
        sdc_ack = 1'b1;
        sdc_busy = 1'b1;
        sdc_q = {8{$urandom()}};
        if (req_we) mem[req_addr] = req_data;
        ctl_busy_phase = 1;
        @(negedge clk);
        sdc_ack = 1'b0;
        chk("start_fall", 64'(sdc_start), 64'(0));
        blen = (force_blen >= 0) ? force_blen : $urandom_range(0, 3);
        repeat (blen) begin
          sdc_q = {8{$urandom()}};
          @(negedge clk);
        end
        sdc_busy = 1'b0;
        sdc_q = line_of(req_addr);
        fall_cyc = cyc;
        ctl_busy_phase = 0;
      end
    end
  end

  // Cache model: which line holds which tag; data always equals SDRAM contents.
  bit          m_valid [8];
  logic [17:0] m_tag [8];
  logic [31:0] m_last_q = '0;
  bit          exp_pending = 0;
  logic [31:0] exp_q = '0;

  // Compare process: every completion must be expected and carry the expected data.
  initial begin : cmp
    wait (rst_done);
    forever begin
      @(posedge clk);
      #1;
      if (cpu_done === 1'b1) begin
        chk("done_expected", 64'(exp_pending), 64'(1));
        chk("cpu_q", 64'(cpu_q), 64'(exp_q));
        chk("busy_at_done", 64'(cpu_busy), 64'(0));
        exp_pending = 0;
      end else if (!exp_pending) begin
        chk("idle_not_busy", 64'(cpu_busy), 64'(0));
      end
    end
  end

  // One CPU transaction; called and returns at 2 time units after a rising edge.
  task automatic do_op(input logic [23:0] a, input logic we, input logic [31:0] d, input bit noise);
    int  idx;
    int  n0;
    bit  hit;
    bit  got;
    idx = int'(a[5:3]);
    hit = !we && m_valid[idx] && (m_tag[idx] == a[23:6]);
    n0  = n_req;
    exp_q = we ? m_last_q : mem_rd(a);
    exp_pending = 1;
    cpu_addr = a;
    cpu_we = we;
    cpu_data = d;
    cpu_start = 1'b1;
    @(posedge clk);
    #2;
    cpu_start = 1'b0;
    if (hit) begin
      chk("hit_latency", 64'(cpu_done), 64'(1));
      chk("hit_no_sdram", 64'(n_req), 64'(n0));
    end else begin
      chk("miss_no_early_done", 64'(cpu_done), 64'(0));
      got = 0;
      for (int k = 0; k < 80; k++) begin
        if (noise) begin
          cpu_start = 1'($urandom_range(0, 1));
          cpu_addr = 24'($urandom());
          cpu_we = 1'($urandom_range(0, 1));
          cpu_data = $urandom();
        end
        @(posedge clk);
        #2;
        if (cpu_done === 1'b1) begin
          got = 1;
          break;
        end
      end
      cpu_start = 1'b0;
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL op_timeout: no cpu_done for addr %0h within 80 cycles", a);
        exp_pending = 0;
      end else begin
        chk("done_timing", 64'(cyc), 64'(fall_cyc + 1));
        chk("one_request", 64'(n_req), 64'(n0 + 1));
        chk("req_addr", 64'(req_addr), we ? 64'(a) : 64'({a[23:3], 3'b000}));
        chk("req_we", 64'(req_we), 64'(we));
        if (we) chk("req_data", 64'(req_data), 64'(d));
      end
    end
    if (!we) begin
      m_valid[idx] = 1;
      m_tag[idx] = a[23:6];
      m_last_q = exp_q;
    end
  endtask

  task automatic pulse_chk();
    @(posedge clk);
    #2;
    chk("done_one_cycle", 64'(cpu_done), 64'(0));
  endtask

  initial begin : main
    int n0;
    int gap;
    logic [23:0] a;
    reset = 1'b1;
    cpu_addr = '0;
    cpu_data = '0;
    cpu_we = 1'b0;
    cpu_start = 1'b0;
    for (int i = 0; i < 8; i++) mem[24'h10 + 24'(i)] = 32'h1000 + 32'(i);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outputs", 64'({cpu_q, cpu_done, cpu_busy, sdc_start, sdc_we}), 64'(0));
    chk("rst_sdc_bus", 64'({sdc_addr, sdc_data}), 64'(0));
    reset = 1'b0;
    rst_done = 1;
    @(posedge clk);
    #2;

    // 1: cold miss on 0x10.
    do_op(24'h000010, 1'b0, 32'h0, 1'b0);
    chk("t1_q", 64'(cpu_q), 64'(32'h1000));
    chk("t1_addr", 64'(req_addr), 64'(24'h000010));
    pulse_chk();
    // 2: hit on 0x13.
    n0 = n_req;
    do_op(24'h000013, 1'b0, 32'h0, 1'b0);
    chk("t2_q", 64'(cpu_q), 64'(32'h1003));
    chk("t2_no_req", 64'(n_req), 64'(n0));
    pulse_chk();
    // 3: write hit, then read it back from the cache.
    do_op(24'h000013, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("t3_wr", 64'({req_we, req_addr, req_data}), 64'({1'b1, 24'h000013, 32'hDEADBEEF}));
    chk("t3_q_held", 64'(cpu_q), 64'(32'h1003));
    n0 = n_req;
    do_op(24'h000013, 1'b0, 32'h0, 1'b0);
    chk("t3_q", 64'(cpu_q), 64'(32'hDEADBEEF));
    chk("t3_no_req", 64'(n_req), 64'(n0));
    // 4: conflict miss evicts, original line refetched.
    do_op(24'h000410, 1'b0, 32'h0, 1'b0);
    chk("t4_addr", 64'(req_addr), 64'(24'h000410));
    chk("t4_q", 64'(cpu_q), 64'(32'h5A000410));
    n0 = n_req;
    do_op(24'h000010, 1'b0, 32'h0, 1'b0);
    chk("t4_refetch", 64'({n_req, req_addr}), 64'({n0 + 1, 24'h000010}));
    chk("t4_q2", 64'(cpu_q), 64'(32'h1000));
    // 5: write miss does not allocate.
    do_op(24'h000200, 1'b1, 32'hCAFE0200, 1'b0);
    n0 = n_req;
    do_op(24'h000200, 1'b0, 32'h0, 1'b0);
    chk("t5_miss", 64'({n_req, req_addr}), 64'({n0 + 1, 24'h000200}));
    chk("t5_q", 64'(cpu_q), 64'(32'hCAFE0200));
    // Re-cache 0x13 so the reset test has a known hit to lose.
    do_op(24'h000013, 1'b0, 32'h0, 1'b0);

    // 6: reset while waiting for a refill.
    force_blen = 8;
    exp_pending = 1;
    cpu_addr = 24'h000530;
    cpu_we = 1'b0;
    cpu_start = 1'b1;
    @(posedge clk);
    #2;
    cpu_start = 1'b0;
    for (int k = 0; k < 20 && !ctl_busy_phase; k++) begin
      @(posedge clk);
      #2;
    end
    chk("t6_in_wait", 64'({ctl_busy_phase, cpu_busy}), 64'({1'b1, 1'b1}));
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_pending = 0;
    chk("t6_after_rst", 64'({sdc_start, cpu_done, cpu_busy}), 64'(0));
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    m_last_q = '0;
    force_blen = -1;
    repeat (15) @(posedge clk);
    #2;
    n0 = n_req;
    do_op(24'h000013, 1'b0, 32'h0, 1'b0);
    chk("t6_lost_hit", 64'({n_req, req_addr}), 64'({n0 + 1, 24'h000010}));
    chk("t6_q", 64'(cpu_q), 64'(32'hDEADBEEF));

    // Random traffic over a few tags so hits, conflicts and write hits all occur.
    for (int n = 0; n < 300; n++) begin
      a = {1'($urandom_range(0, 1)), 15'd0, 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      do_op(a, ($urandom_range(0, 9) < 3), $urandom(), 1'b1);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end

    repeat (5) @(posedge clk);
    #2;
    chk("final_idle", 64'({exp_pending, cpu_busy, sdc_start}), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
